// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues one imem read at a time from currentpc,
// buffers {pc, instr} pairs in a small IF/ID FIFO and closes the PC loop
// through nextpc/pc_stall. Redirects flush the FIFO and drop stale responses.
// Optional performance counters are enabled with `define FETCH_PERF_EN.
module instr_fetch_unit #(
    parameter int unsigned ADDR_W  = 64,
    parameter int unsigned INSTR_W = 32,
    parameter int unsigned DEPTH   = 2,
    parameter int unsigned PC_INC  = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  currentpc,
    output logic [ADDR_W-1:0]  nextpc,
    output logic               pc_stall,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [ADDR_W-1:0]  imem_req_addr,
    input  logic               imem_resp_valid,
    input  logic [INSTR_W-1:0] imem_resp_data,
    output logic               if_valid,
    output logic [ADDR_W-1:0]  if_pc,
    output logic [INSTR_W-1:0] if_instr,
`ifdef FETCH_PERF_EN
    output logic [31:0]        perf_stall_cycles,
    output logic [31:0]        perf_redirects,
    output logic [31:0]        perf_dropped,
`endif
    input  logic               id_ready
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic [ADDR_W-1:0]  req_pc;
    logic [ADDR_W-1:0]  fifo_pc    [DEPTH];
    logic [INSTR_W-1:0] fifo_instr [DEPTH];
    logic               req_fire;
    logic               push;
    logic               pop;
    logic               full;
    logic               empty;

    assign full          = (count == CNT_W'(DEPTH));
    assign empty         = (count == '0);
    assign imem_req_addr = currentpc;
    assign if_pc         = fifo_pc[rd_ptr];
    assign if_instr      = fifo_instr[rd_ptr];

    // Next-state, request issue, FIFO control and PC feedback.
    always_comb begin
        state_nxt      = state;
        imem_req_valid = 1'b0;
        req_fire       = 1'b0;
        push           = 1'b0;
        pop            = 1'b0;
        pc_stall       = 1'b1;
        nextpc         = '0;
        if_valid       = 1'b0;
        if (!reset) begin
            imem_req_valid = (state == S_REQ) && !full && !redirect_valid;
            req_fire       = imem_req_valid && imem_req_ready;
            push           = (state == S_WAIT) && imem_resp_valid && !redirect_valid;
            pop            = id_ready && !empty && !redirect_valid;
            pc_stall       = !(req_fire || redirect_valid);
            nextpc         = redirect_valid ? redirect_pc : currentpc + ADDR_W'(PC_INC);
            if_valid       = !empty;
            case (state)
                S_REQ:   if (req_fire) state_nxt = S_WAIT;
                S_WAIT:  if (imem_resp_valid) state_nxt = S_REQ;
                         else if (redirect_valid) state_nxt = S_DRAIN;
                S_DRAIN: if (imem_resp_valid) state_nxt = S_REQ;
                default: state_nxt = S_REQ;
            endcase
        end
    end

    // State register and outstanding-request PC.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_REQ;
            req_pc <= '0;
        end else begin
            state <= state_nxt;
            if (req_fire) req_pc <= currentpc;
        end
    end

    // FIFO pointers and occupancy; redirect flushes.
    always_ff @(posedge clk) begin
        if (reset || redirect_valid) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      count <= count + CNT_W'(1);
            else if (pop && !push) count <= count - CNT_W'(1);
        end
    end

    // FIFO storage; contents are qualified by count so no reset needed.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[wr_ptr]    <= req_pc;
            fifo_instr[wr_ptr] <= imem_resp_data;
        end
    end

`ifdef FETCH_PERF_EN
    logic dropped;
    assign dropped = imem_resp_valid &&
                     ((state == S_DRAIN) || ((state == S_WAIT) && redirect_valid));

    // Saturating performance counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_stall_cycles <= '0;
            perf_redirects    <= '0;
            perf_dropped      <= '0;
        end else begin
            if (pc_stall && (perf_stall_cycles != '1)) perf_stall_cycles <= perf_stall_cycles + 32'd1;
            if (redirect_valid && (perf_redirects != '1)) perf_redirects <= perf_redirects + 32'd1;
            if (dropped && (perf_dropped != '1)) perf_dropped <= perf_dropped + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed phases followed by a
// randomized run, compared every cycle against a queue-based fetch model.
module tb_instr_fetch_unit;

    localparam int unsigned DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] currentpc;
    logic [63:0] nextpc;
    logic        pc_stall;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        if_valid;
    logic [63:0] if_pc;
    logic [31:0] if_instr;
    logic        id_ready;

    instr_fetch_unit #(.ADDR_W(64), .INSTR_W(32), .DEPTH(DEPTH), .PC_INC(4)) dut (
        .clk(clk), .reset(reset), .currentpc(currentpc), .nextpc(nextpc),
        .pc_stall(pc_stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_resp_valid(imem_resp_valid),
        .imem_resp_data(imem_resp_data), .if_valid(if_valid), .if_pc(if_pc),
        .if_instr(if_instr), .id_ready(id_ready)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [63:0] pc; logic [31:0] instr; } ent_t;
    typedef struct { int due; logic [31:0] data; } mem_t;

    int chk_cnt = 0;
    int pass_cnt = 0;
    int cyc = 0;
    int lat = 1;
    int last_due = -1;

    // Reference model: buffered entries plus the status of the one request in flight.
    ent_t        mq[$];
    int          outst = 0;      // 0 none, 1 live, 2 stale
    logic [63:0] out_pc = '0;
    mem_t        mem_q[$];

    logic        last_rv, last_stall, last_iv, dut_fire;
    logic [63:0] last_next, fire_addr;
    logic [63:0] fa[$];
    int          fc[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt = pass_cnt + 1;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        logic        e_rv, e_stall, e_iv, e_fire;
        logic [63:0] e_next;
        mem_t        m;
        int          d;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        if (mem_q.size() > 0 && mem_q[0].due == cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_q[0].data;
            void'(mem_q.pop_front());
        end
        @(negedge clk);
        if (reset) begin
            e_rv = 0; e_stall = 1; e_next = '0; e_iv = 0; e_fire = 0;
        end else begin
            e_rv    = (outst == 0) && (mq.size() < DEPTH) && !redirect_valid;
            e_fire  = e_rv && imem_req_ready;
            e_next  = redirect_valid ? redirect_pc : currentpc + 64'd4;
            e_stall = !(e_fire || redirect_valid);
            e_iv    = (mq.size() > 0);
        end
        chk("req_valid", 64'(imem_req_valid), 64'(e_rv));
        chk("pc_stall", 64'(pc_stall), 64'(e_stall));
        chk("nextpc", nextpc, e_next);
        chk("if_valid", 64'(if_valid), 64'(e_iv));
        if (e_iv) begin
            chk("if_pc", if_pc, mq[0].pc);
            chk("if_instr", 64'(if_instr), 64'(mq[0].instr));
        end
        if (e_rv) chk("req_addr", imem_req_addr, currentpc);
        last_rv = imem_req_valid; last_stall = pc_stall; last_iv = if_valid;
        last_next = nextpc;
        dut_fire = imem_req_valid && imem_req_ready;
        if (dut_fire) begin
            fire_addr = imem_req_addr;
            fa.push_back(imem_req_addr);
            fc.push_back(cyc);
        end
        // Model update for the coming edge.
        if (reset) begin
            mq.delete();
            outst = 0;
        end else if (redirect_valid) begin
            mq.delete();
            if (outst == 1) outst = imem_resp_valid ? 0 : 2;
            else if (outst == 2 && imem_resp_valid) outst = 0;
        end else begin
            if (id_ready && mq.size() > 0) void'(mq.pop_front());
            if (outst == 1 && imem_resp_valid) begin
                mq.push_back({out_pc, imem_resp_data});
                outst = 0;
            end else if (outst == 2 && imem_resp_valid) begin
                outst = 0;
            end
            if (e_fire) begin
                outst  = 1;
                out_pc = currentpc;
                d = cyc + lat;
                if (d <= last_due) d = last_due + 1;
                last_due = d;
                m.due = d;
                m.data = $urandom;
                mem_q.push_back(m);
            end
        end
        @(posedge clk);
        #1;
        if (!e_stall) currentpc = e_next;
        cyc++;
    endtask

    task automatic wait_fire(input string tag);
        int n = 0;
        do begin
            step();
            n++;
        end while (!dut_fire && n < 40);
        if (!dut_fire) chk({tag, "_timeout"}, 64'(dut_fire), 64'd1);
    endtask

    initial begin
        int nf;
        logic [63:0] pc_save;
        reset = 1; currentpc = 64'h1000; redirect_valid = 0; redirect_pc = '0;
        imem_req_ready = 1; imem_resp_valid = 0; imem_resp_data = '0; id_ready = 1;
        @(posedge clk);
        #1;
        // Reset holds outputs quiet.
        repeat (2) step();
        chk("reset_stall", 64'(last_stall), 64'd1);
        chk("reset_nextpc", last_next, 64'd0);

        // Sequential fetch, latency 1.
        reset = 0; lat = 1;
        fa.delete(); fc.delete();
        repeat (10) step();
        chk("seq_a0", fa[0], 64'h1000);
        chk("seq_a1", fa[1], 64'h1004);
        chk("seq_a2", fa[2], 64'h1008);
        chk("seq_gap1", 64'(fc[1] - fc[0]), 64'd2);
        chk("seq_gap2", 64'(fc[2] - fc[1]), 64'd2);

        // Backpressure: FIFO fills, then one slot opens for one request.
        id_ready = 0;
        repeat (8) step();
        chk("bp_req_valid", 64'(last_rv), 64'd0);
        chk("bp_stall", 64'(last_stall), 64'd1);
        chk("bp_if_valid", 64'(last_iv), 64'd1);
        id_ready = 1;
        step();
        nf = dut_fire ? 1 : 0;
        id_ready = 0;
        repeat (6) begin
            step();
            if (dut_fire) nf++;
        end
        chk("bp_one_fire", 64'(nf), 64'd1);

        // Redirect during WAIT with a slow response.
        id_ready = 1; lat = 3;
        wait_fire("rd_fire");
        redirect_valid = 1; redirect_pc = 64'h2000;
        step();
        chk("rd_nextpc", last_next, 64'h2000);
        chk("rd_stall", 64'(last_stall), 64'd0);
        redirect_valid = 0;
        step();
        chk("rd_flushed", 64'(last_iv), 64'd0);
        if (!dut_fire) wait_fire("rd_refire");
        chk("rd_addr", fire_addr, 64'h2000);

        // Redirect coincident with a response and id_ready.
        lat = 1;
        wait_fire("co_fire");
        redirect_valid = 1; redirect_pc = 64'h3000;
        step();
        redirect_valid = 0;
        step();
        chk("co_empty", 64'(last_iv), 64'd0);
        chk("co_req", 64'(last_rv), 64'd1);
        chk("co_addr", fire_addr, 64'h3000);

        // Address wrap at the top of the space.
        wait_fire("wr_pre");
        redirect_valid = 1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        step();
        redirect_valid = 0;
        wait_fire("wr_fire");
        chk("wr_addr", fire_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("wr_nextpc", last_next, 64'h0);

        // Reset during WAIT; old response lands the cycle after reset drops.
        lat = 3;
        wait_fire("rs_fire");
        step();
        reset = 1;
        step();
        reset = 0;
        pc_save = currentpc;
        step();
        chk("rs_if_valid", 64'(last_iv), 64'd0);
        chk("rs_fire", 64'(dut_fire), 64'd1);
        chk("rs_addr", fire_addr, pc_save);
        repeat (6) step();

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            imem_req_ready = ($urandom_range(0, 3) != 0);
            id_ready       = ($urandom_range(0, 2) != 0);
            lat            = $urandom_range(1, 4);
            redirect_valid = ($urandom_range(0, 11) == 0);
            redirect_pc    = {$urandom, $urandom} & ~64'd3;
            reset          = ($urandom_range(0, 59) == 0);
            step();
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Consumer of the program counter. Takes `currentpc`, issues one instruction-memory read at a time, and buffers returned instructions for decode in a small FIFO (the IF/ID interface).
- Drives `nextpc` and `pc_stall` back into the PC register, closing the fetch loop.
- Handles branch/exception redirects by flushing the FIFO and discarding stale in-flight responses.

Parameters:
- ADDR_W, 64, PC and memory address width.
- INSTR_W, 32, instruction word width.
- DEPTH, 2, IF/ID FIFO entries (power of two, ≥2).
- PC_INC, 4, byte increment for sequential fetch.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- currentpc  in  ADDR_W  PC register output.
- nextpc  out  ADDR_W  next PC value to the PC register.
- pc_stall  out  1  1 = PC holds its value.
- redirect_valid  in  1  taken branch or flush request from a later stage.
- redirect_pc  in  ADDR_W  redirect target.
- imem_req_valid  out  1  read request valid.
- imem_req_ready  in  1  memory accepts the request.
- imem_req_addr  out  ADDR_W  read address.
- imem_resp_valid  in  1  read data valid; one cycle per request, latency ≥1.
- imem_resp_data  in  INSTR_W  instruction word.
- if_valid  out  1  FIFO head valid.
- if_pc  out  ADDR_W  PC of FIFO head.
- if_instr  out  INSTR_W  instruction at FIFO head.
- id_ready  in  1  decode pops the head when `if_valid` is high.

Behaviour:
- FSM states:
  - REQ: no request outstanding.
  - WAIT: one valid request outstanding.
  - DRAIN: one stale request outstanding.
- Reset (synchronous): state=REQ, FIFO count=0, pointers=0, `req_pc`=0.
  - While reset is high: `imem_req_valid`=0, `if_valid`=0, `pc_stall`=1, `nextpc`=0.
- `imem_req_addr` = `currentpc` (combinational).
- `imem_req_valid` = (state==REQ) && (count < DEPTH) && !`redirect_valid`.
- `req_fire` = `imem_req_valid` && `imem_req_ready`.
- `nextpc` = `redirect_valid` ? `redirect_pc` : `currentpc` + PC_INC, modulo 2^ADDR_W (wraps, no flag).
- `pc_stall` = !(`req_fire` || `redirect_valid`), so the PC advances exactly once per issued request or redirect.
- Transitions:
  - REQ, `req_fire`: latch `req_pc`=`currentpc`, go to WAIT.
  - WAIT, `imem_resp_valid`: push {`req_pc`, data}, go to REQ. Request-to-push latency = memory latency; the head is visible the cycle after the push.
  - DRAIN, `imem_resp_valid`: drop the data, go to REQ.
- Redirect (highest priority, any state):
  - FIFO flushed (count=0) at the clock edge; any same-cycle push or pop is ignored.
  - REQ goes to REQ; WAIT goes to DRAIN; DRAIN stays DRAIN.
  - WAIT + same-cycle `imem_resp_valid`: response dropped, go to REQ.
  - DRAIN + same-cycle `imem_resp_valid`: go to REQ.
- FIFO:
  - Push and pop in the same cycle are both honoured; count unchanged.
  - Pop on empty is ignored.
  - Requests issue only when count < DEPTH. With one request outstanding, a response therefore always finds space; no overflow path.
- Full FIFO with `id_ready`=0: no request, `pc_stall`=1, PC frozen; outputs hold stable.
- `imem_resp_valid` in REQ (protocol violation): ignored.
- Reset asserted mid-WAIT: FSM returns to REQ. Any later response arriving in REQ is ignored, per the rule above.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined: adds output ports `perf_stall_cycles` (32), `perf_redirects` (32) and `perf_dropped` (32). They count, respectively: cycles with `pc_stall`=1 outside reset, `redirect_valid` cycles, and responses discarded by DRAIN or same-cycle redirect. All saturate at 2^32-1 and clear on reset.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Sequential fetch, memory latency 1, `id_ready`=1, `currentpc` starts at 0x1000:
  - → requests at 0x1000, 0x1004, 0x1008 every 2 cycles.
  - → `if_pc`/`if_instr` appear in order.
  - → `pc_stall`=0 only on request-fire cycles.
- Backpressure, `id_ready`=0, DEPTH=2:
  - → after 2 pushes, `imem_req_valid`=0 and `pc_stall` held at 1.
  - → after `id_ready`=1 for one cycle, exactly one new request issues.
- Redirect during WAIT to 0x2000, response 3 cycles later:
  - → `nextpc`=0x2000 with `pc_stall`=0 on the redirect cycle, FIFO empty.
  - → stale response dropped, next request address is 0x2000.
- Redirect coincident with `imem_resp_valid` and `id_ready`:
  - → no push, no pop-visible effect, count=0, state=REQ.
- `currentpc`=0xFFFF_FFFF_FFFF_FFFC fires:
  - → `nextpc`=0x0.
- Reset asserted in WAIT, response arrives one cycle after reset deasserts:
  - → response ignored, `if_valid`=0, a fresh request issues at `currentpc`.
